// File: rtl/addsub_pkg.sv
// Shared constants and saturation-bound helpers for the add/subtract pipeline.
package addsub_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Largest representable value: 0111..1 signed, 1111..1 unsigned.
    function automatic logic [63:0] sat_max(input int width, input logic is_signed);
        if (is_signed) begin
            return (64'd1 << (width - 1)) - 64'd1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width, input logic is_signed);
        if (is_signed) begin
            return 64'd1 << (width - 1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result stream bundle for the add/subtract unit.
interface addsub_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_op;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cb;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, in_signed, out_ready,
        input  in_ready, out_valid, out_res, out_cb, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_signed, out_ready,
        output in_ready, out_valid, out_res, out_cb, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_core.sv
// Combinational first-stage math: WIDTH+1-bit raw result, carry/borrow and
// overflow in the selected signedness.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sgn,
    output logic [WIDTH:0]   raw,
    output logic             cb,
    output logic             ovf
);
    logic sign_a;
    logic sign_b;
    logic sign_r;
    logic s_ovf;

    always_comb begin
        if (op == OP_ADD) begin
            raw = {1'b0, a} + {1'b0, b};
        end else begin
            raw = {1'b0, a} - {1'b0, b};
        end
        cb     = raw[WIDTH];
        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
        sign_r = raw[WIDTH-1];
        if (op == OP_ADD) begin
            s_ovf = (sign_a == sign_b) && (sign_r != sign_a);
        end else begin
            s_ovf = (sign_a != sign_b) && (sign_r != sign_a);
        end
        ovf = sgn ? s_ovf : cb;
    end
endmodule

// File: rtl/addsub_pipe.sv
// Two-stage stallable add/subtract unit: S1 holds the raw math, S2 applies
// saturation and presents the result; overflow-event counter sticks at all-ones.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int SAT_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    addsub_if.slave          bus,
    output logic [CNT_W-1:0] ovf_cnt
);
    logic [WIDTH:0]   core_raw;
    logic             core_cb;
    logic             core_ovf;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH:0]   s1_raw_q, s1_raw_d;
    logic             s1_cb_q, s1_cb_d;
    logic             s1_ovf_q, s1_ovf_d;
    logic             s1_op_q, s1_op_d;
    logic             s1_sgn_q, s1_sgn_d;
    logic             s1_asign_q, s1_asign_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_cb_q, s2_cb_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_zero_q, s2_zero_d;

    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic [WIDTH-1:0] sat_hi;
    logic [WIDTH-1:0] sat_lo;
    logic [WIDTH-1:0] sat_res;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a   (bus.in_a),
        .b   (bus.in_b),
        .op  (bus.in_op),
        .sgn (bus.in_signed),
        .raw (core_raw),
        .cb  (core_cb),
        .ovf (core_ovf)
    );

    always_comb begin
        s2_load = !s2_v_q || bus.out_ready;
        s1_load = !s1_v_q || s2_load;
        accept  = bus.in_valid && !rst && s1_load;
    end

    // Signed clamp direction follows A's sign: an overflow always lands on A's side.
    always_comb begin
        sat_hi = WIDTH'(sat_max(WIDTH, s1_sgn_q));
        sat_lo = WIDTH'(sat_min(WIDTH, s1_sgn_q));
        if ((SAT_EN != 0) && s1_ovf_q) begin
            if (s1_sgn_q) begin
                sat_res = s1_asign_q ? sat_lo : sat_hi;
            end else begin
                sat_res = (s1_op_q == OP_ADD) ? sat_hi : sat_lo;
            end
        end else begin
            sat_res = s1_raw_q[WIDTH-1:0];
        end
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_raw_d   = s1_raw_q;
        s1_cb_d    = s1_cb_q;
        s1_ovf_d   = s1_ovf_q;
        s1_op_d    = s1_op_q;
        s1_sgn_d   = s1_sgn_q;
        s1_asign_d = s1_asign_q;
        if (s1_load) begin
            s1_v_d = accept;
            if (accept) begin
                s1_raw_d   = core_raw;
                s1_cb_d    = core_cb;
                s1_ovf_d   = core_ovf;
                s1_op_d    = bus.in_op;
                s1_sgn_d   = bus.in_signed;
                s1_asign_d = bus.in_a[WIDTH-1];
            end
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_res_d  = s2_res_q;
        s2_cb_d   = s2_cb_q;
        s2_ovf_d  = s2_ovf_q;
        s2_zero_d = s2_zero_q;
        if (s2_load) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_res_d  = sat_res;
                s2_cb_d   = s1_cb_q;
                s2_ovf_d  = s1_ovf_q;
                s2_zero_d = (sat_res == '0);
            end
        end
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (s2_v_q && bus.out_ready && s2_ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_raw_q   <= '0;
            s1_cb_q    <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_op_q    <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_asign_q <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_res_q   <= '0;
            s2_cb_q    <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_raw_q   <= s1_raw_d;
            s1_cb_q    <= s1_cb_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_op_q    <= s1_op_d;
            s1_sgn_q   <= s1_sgn_d;
            s1_asign_q <= s1_asign_d;
            s2_v_q     <= s2_v_d;
            s2_res_q   <= s2_res_d;
            s2_cb_q    <= s2_cb_d;
            s2_ovf_q   <= s2_ovf_d;
            s2_zero_q  <= s2_zero_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign bus.in_ready  = !rst && s1_load;
    assign bus.out_valid = s2_v_q;
    assign bus.out_res   = s2_res_q;
    assign bus.out_cb    = s2_cb_q;
    assign bus.out_ovf   = s2_ovf_q;
    assign bus.out_zero  = s2_zero_q;
    assign ovf_cnt       = ovf_cnt_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench: a wrapping (CNT_W=16) and a saturating (CNT_W=2) instance
// share one operand stream; expected beats are queued on accept, checked on emit.
module tb_addsub_pipe;
    import addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cnt_w_o;
    logic [1:0]  cnt_s_o;

    addsub_if #(.WIDTH(5)) bus_w ();
    addsub_if #(.WIDTH(5)) bus_s ();

    assign bus_s.in_valid  = bus_w.in_valid;
    assign bus_s.in_a      = bus_w.in_a;
    assign bus_s.in_b      = bus_w.in_b;
    assign bus_s.in_op     = bus_w.in_op;
    assign bus_s.in_signed = bus_w.in_signed;
    assign bus_s.out_ready = bus_w.out_ready;

    addsub_pipe #(.WIDTH(5), .SAT_EN(0), .CNT_W(16)) dut_w (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_w.slave),
        .ovf_cnt (cnt_w_o)
    );

    addsub_pipe #(.WIDTH(5), .SAT_EN(1), .CNT_W(2)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_s.slave),
        .ovf_cnt (cnt_s_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ew;
        logic [7:0] es;
        int         acc;
        bit         fast;
    } ent_t;

    ent_t       q[$];
    ent_t       e;
    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         mc_w = 0;
    int         mc_s = 0;
    bit         rst_seen = 0;
    bit         stall_prev = 0;
    bit         rdy_mode = 0;
    logic [7:0] held_w, held_s;
    logic [7:0] gw, gs;

    assign gw = {bus_w.out_ovf, bus_w.out_cb, bus_w.out_zero, bus_w.out_res};
    assign gs = {bus_s.out_ovf, bus_s.out_cb, bus_s.out_zero, bus_s.out_res};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference arithmetic on integers; packs {ovf, cb, zero, res}.
    function automatic logic [7:0] model(input logic [4:0] a, input logic [4:0] b,
                                         input logic op, input logic sg, input bit sat);
        int         ua, ub, sa, sb, tv;
        logic       cb, ovf;
        logic [4:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = a[4] ? ua - 32 : ua;
        sb = b[4] ? ub - 32 : ub;
        if (op == OP_ADD) begin
            cb  = (ua + ub) > 31;
            tv  = sa + sb;
            res = 5'((ua + ub) & 31);
        end else begin
            cb  = ua < ub;
            tv  = sa - sb;
            res = 5'((ua - ub) & 31);
        end
        ovf = sg ? (tv > 15 || tv < -16) : cb;
        if (sat && ovf) begin
            if (sg) res = (tv > 0) ? 5'd15 : 5'd16;
            else    res = (op == OP_ADD) ? 5'd31 : 5'd0;
        end
        return {ovf, cb, (res == 5'd0), res};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_in_ready", {30'd0, bus_w.in_ready, bus_s.in_ready}, 32'd0);
            if (rst_seen) begin
                chk("rst_out_valid", {30'd0, bus_w.out_valid, bus_s.out_valid}, 32'd0);
                chk("rst_outs_w", {24'd0, gw}, 32'd0);
                chk("rst_outs_s", {24'd0, gs}, 32'd0);
                chk("rst_cnt", {14'd0, cnt_w_o, cnt_s_o}, 32'd0);
            end
            q.delete();
            mc_w       = 0;
            mc_s       = 0;
            rst_seen   = 1;
            stall_prev = 0;
        end else begin
            rst_seen = 0;
            chk("in_ready", {31'd0, bus_w.in_ready}, {31'd0, (q.size() < 2) || bus_w.out_ready});
            chk("valid_match", {31'd0, bus_s.out_valid}, {31'd0, bus_w.out_valid});
            chk("cnt_wrap", {16'd0, cnt_w_o}, mc_w);
            chk("cnt_sat", {30'd0, cnt_s_o}, mc_s);
            if (stall_prev) begin
                chk("stall_valid", {31'd0, bus_w.out_valid}, 32'd1);
                chk("stall_w", {24'd0, gw}, {24'd0, held_w});
                chk("stall_s", {24'd0, gs}, {24'd0, held_s});
            end
            if (bus_w.out_valid && bus_w.out_ready) begin
                if (q.size() == 0) begin
                    chk("stale_beat", {31'd0, bus_w.out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("res_wrap", {24'd0, gw}, {24'd0, e.ew});
                    chk("res_sat", {24'd0, gs}, {24'd0, e.es});
                    if (e.fast) chk("latency", cyc - e.acc, 32'd2);
                    else        chk("latency_min", {31'd0, (cyc - e.acc) >= 2}, 32'd1);
                    if (e.ew[7] && mc_w < 65535) mc_w++;
                    if (e.es[7] && mc_s < 3)     mc_s++;
                end
            end
            if (bus_w.in_valid && bus_w.in_ready) begin
                q.push_back('{model(bus_w.in_a, bus_w.in_b, bus_w.in_op, bus_w.in_signed, 1'b0),
                              model(bus_w.in_a, bus_w.in_b, bus_w.in_op, bus_w.in_signed, 1'b1),
                              cyc, (!rdy_mode && bus_w.out_ready)});
            end
            stall_prev = bus_w.out_valid && !bus_w.out_ready;
            held_w     = gw;
            held_s     = gs;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode) bus_w.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [4:0] a, input logic [4:0] b, input logic op, input logic sg);
        int g = 0;
        bus_w.in_valid  = 1'b1;
        bus_w.in_a      = a;
        bus_w.in_b      = b;
        bus_w.in_op     = op;
        bus_w.in_signed = sg;
        @(negedge clk);
        while (!bus_w.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("accept_timeout", {31'd0, bus_w.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_w.in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        bus_w.out_ready = 1'b1;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", q.size(), 32'd0);
    endtask

    logic [4:0] bp_a  [8] = '{5'd3, 5'd20, 5'd16, 5'd0, 5'd31, 5'd15, 5'd2, 5'd10};
    logic [4:0] bp_b  [8] = '{5'd5, 5'd15, 5'd1,  5'd1, 5'd31, 5'd15, 5'd1, 5'd3};
    logic       bp_op [8] = '{1'b0, 1'b1,  1'b0,  1'b0, 1'b1,  1'b1,  1'b0, 1'b1};
    logic       bp_sg [8] = '{1'b0, 1'b0,  1'b1,  1'b0, 1'b0,  1'b1,  1'b0, 1'b0};

    initial begin
        bus_w.in_valid  = 1'b0;
        bus_w.in_a      = '0;
        bus_w.in_b      = '0;
        bus_w.in_op     = 1'b0;
        bus_w.in_signed = 1'b0;
        bus_w.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(5'd3,  5'd5,  OP_SUB, 1'b0);
        send(5'd20, 5'd15, OP_ADD, 1'b0);
        send(5'd16, 5'd1,  OP_SUB, 1'b1);
        send(5'd7,  5'd24, OP_SUB, 1'b1);
        send(5'd0,  5'd0,  OP_ADD, 1'b0);
        send(5'd31, 5'd1,  OP_ADD, 1'b0);
        send(5'd15, 5'd1,  OP_ADD, 1'b1);
        send(5'd16, 5'd31, OP_ADD, 1'b1);
        send(5'd5,  5'd5,  OP_SUB, 1'b1);
        send(5'd9,  5'd4,  OP_SUB, 1'b0);
        drain();

        // Fill both stages under a stall, then reset with beats in flight.
        bus_w.out_ready = 1'b0;
        send(5'd1, 5'd2, OP_SUB, 1'b0);
        send(5'd30, 5'd3, OP_ADD, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus_w.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        rdy_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], bp_op[i], bp_sg[i]);
        for (int i = 0; i < 30; i++) begin
            send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rdy_mode = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end
endmodule
